reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
Parameters (one per line: name, default, meaning):
REQ-001 The block SHALL have parameter PLL_RST_CYCLES, default 16, cycles pll_reset is held per attempt (min 1).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 4096, cycles allowed in WAIT_LOCK before retry (min 2).
REQ-003 The block SHALL have parameter MIG_RST_CYCLES, default 16, cycles mig_rst_n is held low after lock (min 1).
REQ-004 The block SHALL have parameter CALIB_TIMEOUT, default 2000000, cycles allowed in WAIT_CALIB before retry (min 2).
REQ-005 The block SHALL have parameter CORE_RST_CYCLES, default 32, cycles core_reset is held after calibration (min 1).
Ports (name  direction  width  meaning):
REQ-006 The block SHALL have port clk  in  1  free-running 100 MHz board clock; sole clock.
REQ-007 The block SHALL have port resetn  in  1  synchronous, active-low reset.
REQ-008 The block SHALL have port pll_locked  in  1  clock-wizard locked, asynchronous.
REQ-009 The block SHALL have port calib_done  in  1  DDR3 controller init_calib_complete, asynchronous.
REQ-010 The block SHALL have port pll_reset  out  1  active-high reset to clock wizard.
REQ-011 The block SHALL have port mig_rst_n  out  1  active-low reset to DDR3 controller.
REQ-012 The block SHALL have port core_reset  out  1  active-high reset to JOP core domain.
REQ-013 The block SHALL have port ready  out  1  high only while fully up.
REQ-014 The block SHALL have port retry_count  out  4  saturating count of timeout retries.
REQ-015 The block SHALL have port state  out  3  current state encoding, for debug.

Function
REQ-016 pll_locked and calib_done SHALL each pass through a 2-flop synchronizer (locked_s, calib_s); the FSM SHALL use only synchronized values (2-cycle input latency).
REQ-017 The FSM SHALL have states PLL_RST=0, WAIT_LOCK=1, MIG_RST=2, WAIT_CALIB=3, CORE_RST=4, RUN=5; codes 6-7 SHALL go to PLL_RST next cycle.
REQ-018 A single cycle counter SHALL clear to 0 on every state change and increment by 1 each cycle otherwise; width SHALL hold max(all parameters) without wrap.
REQ-019 PLL_RST SHALL go to WAIT_LOCK when counter == PLL_RST_CYCLES-1 (exactly PLL_RST_CYCLES cycles in state).
REQ-020 WAIT_LOCK SHALL go to MIG_RST when locked_s=1; else when counter == LOCK_TIMEOUT-1 SHALL go to PLL_RST and increment retry_count.
REQ-021 MIG_RST SHALL go to WAIT_CALIB when counter == MIG_RST_CYCLES-1.
REQ-022 WAIT_CALIB SHALL go to CORE_RST when calib_s=1; else when counter == CALIB_TIMEOUT-1 SHALL go to MIG_RST and increment retry_count.
REQ-023 CORE_RST SHALL go to RUN when counter == CORE_RST_CYCLES-1.
REQ-024 In MIG_RST, WAIT_CALIB, CORE_RST, RUN: locked_s=0 SHALL force PLL_RST next cycle, overriding every other transition (no retry increment).
REQ-025 In CORE_RST or RUN: calib_s=0 with locked_s=1 SHALL force MIG_RST next cycle (no retry increment).
REQ-026 Timeout and success in the same cycle SHALL resolve as success.
REQ-027 retry_count SHALL saturate at 15 and clear only on reset.
REQ-028 Outputs SHALL be decoded from the registered state only: pll_reset=1 iff PLL_RST; mig_rst_n=0 iff state in {PLL_RST, WAIT_LOCK, MIG_RST}; core_reset=1 iff state != RUN; ready=1 iff RUN.

Reset
REQ-029 While resetn=0 at a clk edge: state=PLL_RST, counter=0, synchronizer flops=0, retry_count=0; hence pll_reset=1, mig_rst_n=0, core_reset=1, ready=0.
REQ-030 Assertion of resetn mid-operation SHALL take effect at the next edge regardless of state, restarting the full sequence.

Verification (bench params 4/64/4/256/8)
REQ-031 Nominal: resetn released, pll_locked=1 and calib_done=1 stable -> pll_reset high 4 cycles, WAIT_LOCK 1 cycle, MIG_RST 4, WAIT_CALIB 1, CORE_RST 8, then ready=1, retry_count=0.
REQ-032 Lock timeout: pll_locked held 0 -> PLL_RST/WAIT_LOCK loop of 68 cycles per attempt, retry_count 1,2,...,15 then stays 15; ready never 1.
REQ-033 Lock loss in RUN: drop pll_locked 1 cycle -> state=PLL_RST exactly 3 cycles after the drop edge, core_reset=1, ready=0, retry_count unchanged.
REQ-034 Calib loss in RUN: drop calib_done, pll_locked=1 -> MIG_RST 3 cycles later, mig_rst_n=0 for 4 cycles, sequence resumes to RUN.
REQ-035 Calib timeout: calib_done held 0 -> MIG_RST/WAIT_CALIB loop of 260 cycles, retry_count increments each pass; pll_reset stays 0.
REQ-036 Mid-sequence reset: resetn=0 for 1 cycle during WAIT_CALIB with retry_count=2 -> next edge state=PLL_RST, retry_count=0, all outputs at reset values.

Source files
------------

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - power-up reset sequencer for clock wizard, DDR3 controller and core domain
//
// Brings the board up in order: clock wizard reset, wait for PLL lock, DDR3
// controller reset, wait for calibration, core reset, then run. Each wait has
// a timeout that retries the stage and bumps a saturating retry counter. Loss
// of lock or calibration after the relevant stage drops the sequence back.
//
// Ports:
//   clk          in   free-running board clock, sole clock
//   resetn       in   synchronous active-low reset
//   pll_locked   in   clock wizard locked (asynchronous, synchronized here)
//   calib_done   in   DDR3 init_calib_complete (asynchronous, synchronized here)
//   pll_reset    out  active-high reset to clock wizard
//   mig_rst_n    out  active-low reset to DDR3 controller
//   core_reset   out  active-high reset to core domain
//   ready        out  high only in RUN
//   retry_count  out  saturating count of timeout retries
//   state        out  current state encoding, for debug

module reset_sequencer #(
  parameter int PLL_RST_CYCLES  = 16,
  parameter int LOCK_TIMEOUT    = 4096,
  parameter int MIG_RST_CYCLES  = 16,
  parameter int CALIB_TIMEOUT   = 2000000,
  parameter int CORE_RST_CYCLES = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_locked,
  input  logic       calib_done,
  output logic       pll_reset,
  output logic       mig_rst_n,
  output logic       core_reset,
  output logic       ready,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_PARAM = max2(max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                       max2(MIG_RST_CYCLES, CALIB_TIMEOUT)),
                                  CORE_RST_CYCLES);
  localparam int CW = $clog2(MAX_PARAM + 1);

  localparam logic [CW-1:0] PLL_LAST   = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] MIG_LAST   = CW'(MIG_RST_CYCLES - 1);
  localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_TIMEOUT - 1);
  localparam logic [CW-1:0] CORE_LAST  = CW'(CORE_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_PLL_RST    = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_MIG_RST    = 3'd2,
    ST_WAIT_CALIB = 3'd3,
    ST_CORE_RST   = 3'd4,
    ST_RUN        = 3'd5
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [CW-1:0] cnt_q;
  logic          retry_inc;
  logic          locked_m;
  logic          locked_s;
  logic          calib_m;
  logic          calib_s;

  // Two-flop synchronizers; the FSM only ever looks at the _s outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
      calib_m  <= 1'b0;
      calib_s  <= 1'b0;
    end else begin
      locked_m <= pll_locked;
      locked_s <= locked_m;
      calib_m  <= calib_done;
      calib_s  <= calib_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_PLL_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Cycle counter restarts on every state change. It holds at all-ones
  // instead of wrapping, which only matters while parked in RUN.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (cnt_q != {CW{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      retry_count <= 4'd0;
    end else if (retry_inc && (retry_count != 4'hf)) begin
      retry_count <= retry_count + 4'd1;
    end
  end

  // Priority in every post-lock state: lock loss first, then calibration
  // loss, then success, then timeout (so a coincident success wins).
  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PLL_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_MIG_RST;
        end else if (cnt_q == LOCK_LAST) begin
          state_d   = ST_PLL_RST;
          retry_inc = 1'b1;
        end
      end
      ST_MIG_RST: begin
        if (!locked_s) begin
          state_d = ST_PLL_RST;
        end else if (cnt_q == MIG_LAST) begin
          state_d = ST_WAIT_CALIB;
        end
      end
      ST_WAIT_CALIB: begin
        if (!locked_s) begin
          state_d = ST_PLL_RST;
        end else if (calib_s) begin
          state_d = ST_CORE_RST;
        end else if (cnt_q == CALIB_LAST) begin
          state_d   = ST_MIG_RST;
          retry_inc = 1'b1;
        end
      end
      ST_CORE_RST: begin
        if (!locked_s) begin
          state_d = ST_PLL_RST;
        end else if (!calib_s) begin
          state_d = ST_MIG_RST;
        end else if (cnt_q == CORE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_PLL_RST;
        end else if (!calib_s) begin
          state_d = ST_MIG_RST;
        end
      end
      default: begin
        state_d = ST_PLL_RST;
      end
    endcase
  end

  assign pll_reset  = (state_q == ST_PLL_RST);
  assign mig_rst_n  = !((state_q == ST_PLL_RST) || (state_q == ST_WAIT_LOCK) ||
                        (state_q == ST_MIG_RST));
  assign core_reset = (state_q != ST_RUN);
  assign ready      = (state_q == ST_RUN);
  assign state      = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed vector bench for reset_sequencer

module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_locked = 1'b1;
  logic       calib_done = 1'b1;
  logic       pll_reset;
  logic       mig_rst_n;
  logic       core_reset;
  logic       ready;
  logic [3:0] retry_count;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (64),
    .MIG_RST_CYCLES (4),
    .CALIB_TIMEOUT  (256),
    .CORE_RST_CYCLES(8)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pll_locked (pll_locked),
    .calib_done (calib_done),
    .pll_reset  (pll_reset),
    .mig_rst_n  (mig_rst_n),
    .core_reset (core_reset),
    .ready      (ready),
    .retry_count(retry_count),
    .state      (state)
  );

  typedef struct {
    logic       rn;
    logic       lk;
    logic       cd;
    logic [10:0] exp; // {state, pll_reset, mig_rst_n, core_reset, ready, retry_count}
  } vec_t;

  vec_t vq[$];

  function automatic logic [10:0] outs();
    return {state, pll_reset, mig_rst_n, core_reset, ready, retry_count};
  endfunction

  task automatic push(input logic rn, input logic lk, input logic cd, input int n,
                      input logic [2:0] st, input logic pr, input logic mn,
                      input logic cr, input logic rd, input logic [3:0] rc);
    vec_t v;
    v.rn = rn; v.lk = lk; v.cd = cd;
    v.exp = {st, pr, mn, cr, rd, rc};
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset edge becomes edge index 0; caller then counts edges from there.
  task automatic do_reset(input logic lk, input logic cd);
    resetn = 1'b0; pll_locked = lk; calib_done = cd;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    int k;
    int cnt;
    int bad;
    logic seen;
    logic [3:0] prev;

    // Nominal bring-up, one row per clock edge.
    push(0, 1, 1, 2, 3'd0, 1, 0, 1, 0, 0);
    push(1, 1, 1, 3, 3'd0, 1, 0, 1, 0, 0);
    push(1, 1, 1, 1, 3'd1, 0, 0, 1, 0, 0);
    push(1, 1, 1, 4, 3'd2, 0, 0, 1, 0, 0);
    push(1, 1, 1, 1, 3'd3, 0, 1, 1, 0, 0);
    push(1, 1, 1, 8, 3'd4, 0, 1, 1, 0, 0);
    push(1, 1, 1, 2, 3'd5, 0, 1, 0, 1, 0);

    #1;
    foreach (vq[i]) begin
      resetn = vq[i].rn; pll_locked = vq[i].lk; calib_done = vq[i].cd;
      tick();
      chk($sformatf("nominal[%0d]", i), 32'(outs()), 32'(vq[i].exp));
    end

    // Lock loss in RUN: one-cycle drop of pll_locked.
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    chk("lockloss_still_run", 32'(state), 32'd5);
    tick();
    chk("lockloss_outs", 32'(outs()), 32'({3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0}));
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      seen = ready;
    end
    chk("lockloss_recover_ready", 32'(seen), 32'd1);
    chk("lockloss_retry", 32'(retry_count), 32'd0);

    // Calibration loss in RUN.
    calib_done = 1'b0;
    tick();
    tick();
    chk("calloss_still_run", 32'(state), 32'd5);
    tick();
    chk("calloss_state", 32'(state), 32'd2);
    calib_done = 1'b1;
    cnt = 1; // current sample already shows mig_rst_n low
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (!mig_rst_n) cnt++;
      if (pll_reset) cnt += 100;
      seen = ready;
    end
    chk("calloss_mig_low_cycles", 32'(cnt), 32'd4);
    chk("calloss_recover_ready", 32'(seen), 32'd1);
    chk("calloss_retry", 32'(retry_count), 32'd0);

    // Lock timeout: 68 cycles per attempt, retry saturates at 15.
    do_reset(1'b0, 1'b1);
    k = 0; seen = 1'b0; prev = retry_count;
    for (int i = 1; i <= 16 * 68 + 40; i++) begin
      tick();
      if (ready) seen = 1'b1;
      if (retry_count != prev) begin
        k++;
        chk($sformatf("locktmo_edge_k%0d", k), 32'(i), 32'(k * 68));
        chk($sformatf("locktmo_val_k%0d", k), 32'(retry_count), 32'(k));
        prev = retry_count;
      end
    end
    chk("locktmo_num_incr", 32'(k), 32'd15);
    chk("locktmo_final", 32'(retry_count), 32'd15);
    chk("locktmo_never_ready", 32'(seen), 32'd0);

    // Calibration timeout: 260-cycle MIG_RST/WAIT_CALIB loop, then mid-sequence reset.
    do_reset(1'b1, 1'b0);
    k = 0; bad = 0; prev = retry_count;
    for (int i = 1; i <= 530; i++) begin
      tick();
      if (i >= 4 && pll_reset) bad++;
      if (retry_count != prev) begin
        k++;
        chk($sformatf("caltmo_edge_k%0d", k), 32'(i), 32'(265 + (k - 1) * 260));
        prev = retry_count;
      end
    end
    chk("caltmo_pll_reset_low", 32'(bad), 32'd0);
    chk("caltmo_state_wait_calib", 32'(state), 32'd3);
    chk("caltmo_retry", 32'(retry_count), 32'd2);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("midreset_outs", 32'(outs()), 32'({3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0}));
    tick();
    chk("midreset_restart", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
